// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD responder: nibble-FSM states,
// command/nibble constants and display RAM geometry.
package lcd_pkg;

    // Nibble state machine: three init nibbles, wait for the 4-bit switch,
    // then alternate between high and low nibble of each byte.
    typedef enum logic [2:0] {
        ST_INIT0 = 3'd0,
        ST_INIT1 = 3'd1,
        ST_INIT2 = 3'd2,
        ST_WAIT4 = 3'd3,
        ST_HI    = 3'd4,
        ST_LO    = 3'd5
    } nib_state_t;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam int         CMD_SET_DDRAM = 7;
    localparam logic [3:0] INIT_NIBBLE   = 4'h3;
    localparam logic [3:0] MODE4_NIBBLE  = 4'h2;
    localparam logic [7:0] BLANK_CHAR    = 8'h20;
    localparam int         RAM_DEPTH     = 128;

endpackage

// File: rtl/lcd_ddram.sv
// 128x8 display RAM: one synchronous write port, one registered read port.
// A read and write to the same address in one cycle returns the old value.
module lcd_ddram (
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [0:127];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port (read-before-write on address collision)
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/lcd_responder.sv
// Character-LCD controller model: samples the LCD pins, runs the 4-bit init
// handshake, pairs nibbles into bytes and executes set-address / data-write
// commands into a 128-byte display RAM.
// Optional feature: define LCD_RESP_CLEAR_EN to build the clear-display fill
// engine (command 0x01 blanks the RAM over CLEAR_CYCLES busy cycles).
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int CLEAR_CYCLES = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcde,
    input  logic       lcdrs,
    input  logic       lcdrw,
    input  logic [3:0] lcddat,
    output logic       byte_valid,
    output logic       byte_rs,
    output logic [7:0] byte_data,
    output logic [6:0] ddram_addr,
    output logic       mode_4bit,
    output logic       busy,
    output logic       proto_err,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data
);

    logic       lcde_reg;
    logic       lcdrs_reg;
    logic       lcdrw_reg;
    logic [3:0] lcddat_reg;

    nib_state_t state_reg;
    nib_state_t state_next;

    logic       byte_valid_reg;
    logic       byte_rs_reg;
    logic [7:0] byte_data_reg;
    logic       held_rs_reg;
    logic [6:0] ddram_addr_reg;
    logic       mode_4bit_reg;
    logic       proto_err_reg;

    logic       strobe;
    logic       accept;
    logic       reject;
    logic       busy_int;
    logic       is_init;
    logic       is_mode4;
    logic       fsm_err;
    logic       set_mode;
    logic       latch_hi;
    logic       emit;
    logic [7:0] emit_byte;
    logic       exec_data;
    logic       exec_set;

    logic       ram_we;
    logic [6:0] ram_addr;
    logic [7:0] ram_wdata;

    // Register the pins every cycle; the strobe is the falling edge of lcde
    always_ff @(posedge clk) begin
        if (reset) begin
            lcde_reg   <= 1'b0;
            lcdrs_reg  <= 1'b0;
            lcdrw_reg  <= 1'b0;
            lcddat_reg <= 4'h0;
        end else begin
            lcde_reg   <= lcde;
            lcdrs_reg  <= lcdrs;
            lcdrw_reg  <= lcdrw;
            lcddat_reg <= lcddat;
        end
    end

    assign strobe   = lcde_reg & ~lcde;
    assign accept   = strobe & ~lcdrw_reg & ~busy_int;
    assign reject   = strobe & (lcdrw_reg | busy_int);
    assign is_init  = ~lcdrs_reg & (lcddat_reg == INIT_NIBBLE);
    assign is_mode4 = ~lcdrs_reg & (lcddat_reg == MODE4_NIBBLE);

    // Nibble FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_INIT0;
        end else begin
            state_reg <= state_next;
        end
    end

    // Nibble FSM next-state: only accepted strobes move the machine
    always_comb begin
        state_next = state_reg;
        if (accept) begin
            case (state_reg)
                ST_INIT0: if (is_init)  state_next = ST_INIT1;
                ST_INIT1: if (is_init)  state_next = ST_INIT2;
                ST_INIT2: if (is_init)  state_next = ST_WAIT4;
                ST_WAIT4: if (is_mode4) state_next = ST_HI;
                ST_HI:    state_next = ST_LO;
                ST_LO:    state_next = ST_HI;
                default:  state_next = ST_INIT0;
            endcase
        end
    end

    // Nibble FSM outputs: per-strobe actions and handshake errors
    always_comb begin
        fsm_err  = 1'b0;
        set_mode = 1'b0;
        latch_hi = 1'b0;
        emit     = 1'b0;
        if (accept) begin
            case (state_reg)
                ST_INIT0, ST_INIT1, ST_INIT2: fsm_err = ~is_init;
                ST_WAIT4: begin
                    set_mode = is_mode4;
                    fsm_err  = ~is_mode4 & ~is_init;
                end
                ST_HI: latch_hi = 1'b1;
                ST_LO: begin
                    emit    = 1'b1;
                    fsm_err = (lcdrs_reg != held_rs_reg);
                end
                default: fsm_err = 1'b0;
            endcase
        end
    end

    // The byte type follows the RS captured with the high nibble
    assign emit_byte = {byte_data_reg[7:4], lcddat_reg};
    assign exec_data = emit & held_rs_reg;
    assign exec_set  = emit & ~held_rs_reg & emit_byte[CMD_SET_DDRAM];

`ifdef LCD_RESP_CLEAR_EN
    localparam int CNT_W = $clog2(CLEAR_CYCLES) + 1;

    logic             exec_clear;
    logic             clear_req_reg;
    logic             busy_reg;
    logic [CNT_W-1:0] fill_cnt_reg;
    logic             fill_we;

    assign exec_clear = emit & ~held_rs_reg & (emit_byte == CMD_CLEAR);

    // Clear engine: busy starts the cycle after byte_valid and lasts CLEAR_CYCLES
    always_ff @(posedge clk) begin
        if (reset) begin
            clear_req_reg <= 1'b0;
            busy_reg      <= 1'b0;
            fill_cnt_reg  <= '0;
        end else begin
            clear_req_reg <= exec_clear;
            if (clear_req_reg) begin
                busy_reg     <= 1'b1;
                fill_cnt_reg <= '0;
            end else if (busy_reg) begin
                if (fill_cnt_reg == CNT_W'(CLEAR_CYCLES - 1)) begin
                    busy_reg <= 1'b0;
                end
                fill_cnt_reg <= fill_cnt_reg + 1'b1;
            end
        end
    end

    // Fill one address per busy cycle; byte writes cannot occur while busy
    assign fill_we   = busy_reg & (fill_cnt_reg < CNT_W'(RAM_DEPTH));
    assign busy_int  = busy_reg;
    assign ram_we    = exec_data | fill_we;
    assign ram_addr  = fill_we ? fill_cnt_reg[6:0] : ddram_addr_reg;
    assign ram_wdata = fill_we ? BLANK_CHAR : emit_byte;
`else
    // Clear length only matters when the fill engine is built
    logic clear_len_unused;
    assign clear_len_unused = (CLEAR_CYCLES < RAM_DEPTH);

    assign busy_int  = 1'b0;
    assign ram_we    = exec_data;
    assign ram_addr  = ddram_addr_reg;
    assign ram_wdata = emit_byte;
`endif

    // Byte assembly, address counter, mode and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_valid_reg <= 1'b0;
            byte_rs_reg    <= 1'b0;
            byte_data_reg  <= 8'h00;
            held_rs_reg    <= 1'b0;
            ddram_addr_reg <= 7'h00;
            mode_4bit_reg  <= 1'b0;
            proto_err_reg  <= 1'b0;
        end else begin
            byte_valid_reg <= emit;
            if (latch_hi) begin
                byte_data_reg[7:4] <= lcddat_reg;
                held_rs_reg        <= lcdrs_reg;
            end
            if (emit) begin
                byte_data_reg[3:0] <= lcddat_reg;
                byte_rs_reg        <= held_rs_reg;
            end
            if (set_mode) begin
                mode_4bit_reg <= 1'b1;
            end
            if (reject | fsm_err) begin
                proto_err_reg <= 1'b1;
            end
            if (exec_data) begin
                ddram_addr_reg <= ddram_addr_reg + 7'd1;
            end else if (exec_set) begin
                ddram_addr_reg <= emit_byte[6:0];
`ifdef LCD_RESP_CLEAR_EN
            end else if (exec_clear) begin
                ddram_addr_reg <= 7'h00;
`endif
            end
        end
    end

    lcd_ddram u_ddram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (ram_addr),
        .wr_data (ram_wdata),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign byte_valid = byte_valid_reg;
    assign byte_rs    = byte_rs_reg;
    assign byte_data  = byte_data_reg;
    assign ddram_addr = ddram_addr_reg;
    assign mode_4bit  = mode_4bit_reg;
    assign busy       = busy_int;
    assign proto_err  = proto_err_reg;

endmodule

// File: tb/tb_lcd_responder.sv
// Self-checking bench for lcd_responder: directed LCD pin transactions, a
// transaction-level model of the controller checked every cycle, and literal
// expectations for the key scenarios. Honours LCD_RESP_CLEAR_EN.
module tb_lcd_responder;

    localparam int CLR = 128;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lcde = 1'b0;
    logic       lcdrs = 1'b0;
    logic       lcdrw = 1'b0;
    logic [3:0] lcddat = 4'h0;
    logic [6:0] rd_addr = 7'h00;

    logic       byte_valid;
    logic       byte_rs;
    logic [7:0] byte_data;
    logic [6:0] ddram_addr;
    logic       mode_4bit;
    logic       busy;
    logic       proto_err;
    logic [7:0] rd_data;

    lcd_responder #(.CLEAR_CYCLES(CLR)) dut (
        .clk        (clk),
        .reset      (reset),
        .lcde       (lcde),
        .lcdrs      (lcdrs),
        .lcdrw      (lcdrw),
        .lcddat     (lcddat),
        .byte_valid (byte_valid),
        .byte_rs    (byte_rs),
        .byte_data  (byte_data),
        .ddram_addr (ddram_addr),
        .mode_4bit  (mode_4bit),
        .busy       (busy),
        .proto_err  (proto_err),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cycles = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!reset && busy) busy_cycles <= busy_cycles + 1;

    // Transaction-level model state
    bit         m_valid;
    bit         m_rs;
    logic [7:0] m_data;
    logic [6:0] m_addr;
    bit         m_mode;
    bit         m_err;
    int         m_init;
    bit         m_have_hi;
    logic [3:0] m_hi;
    bit         m_hi_rs;
    int         busy_start = -1;
    logic [7:0] ram_m [128];
    bit         ram_known [128];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit busy_at(input int c);
        return (busy_start >= 0) && (c >= busy_start) && (c < busy_start + CLR);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rs = 0; m_data = 8'h00; m_addr = 7'h00;
        m_mode = 0; m_err = 0; m_init = 0; m_have_hi = 0;
        m_hi = 4'h0; m_hi_rs = 0; busy_start = -1;
    endtask

    // Effect of one strobe; called right after the edge that detects it
    task automatic model_apply(input bit rs, input bit rw, input logic [3:0] nib);
        logic [7:0] b;
        if (rw || busy_at(cyc - 1)) begin
            m_err = 1;
        end else if (!m_mode) begin
            if (m_init < 3) begin
                if (!rs && nib == 4'h3) m_init++;
                else m_err = 1;
            end else if (!rs && nib == 4'h2) begin
                m_mode = 1;
            end else if (!(!rs && nib == 4'h3)) begin
                m_err = 1;
            end
        end else if (!m_have_hi) begin
            m_hi = nib; m_hi_rs = rs; m_have_hi = 1;
        end else begin
            b = {m_hi, nib};
            m_have_hi = 0;
            if (rs != m_hi_rs) m_err = 1;
            m_valid = 1; m_rs = m_hi_rs; m_data = b;
            if (m_hi_rs) begin
                ram_m[m_addr] = b; ram_known[m_addr] = 1;
                m_addr = m_addr + 7'd1;
            end else if (b >= 8'h80) begin
                m_addr = b[6:0];
            end else if (b == 8'h01) begin
`ifdef LCD_RESP_CLEAR_EN
                m_addr = 7'h00;
                busy_start = cyc + 1;
                for (int i = 0; i < 128; i++) begin
                    ram_m[i] = 8'h20; ram_known[i] = 1;
                end
`endif
            end
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (!reset) begin
            chk("byte_valid", byte_valid, m_valid);
            chk("mode_4bit", mode_4bit, m_mode);
            chk("proto_err", proto_err, m_err);
            chk("ddram_addr", ddram_addr, m_addr);
            chk("busy", busy, busy_at(cyc));
            if (m_valid) begin
                chk("byte_rs", byte_rs, m_rs);
                chk("byte_data", byte_data, m_data);
            end
        end
    end

    task automatic strobe(input bit rs, input bit rw, input logic [3:0] nib);
        @(posedge clk); #1;
        lcde = 1; lcdrs = rs; lcdrw = rw; lcddat = nib;
        @(posedge clk); #1;
        lcde = 0;
        @(posedge clk); #1;
        model_apply(rs, rw, nib);
        $display("strobe rs=%0b rw=%0b nib=%0h -> addr=%0h mode=%0b err=%0b", rs, rw, nib, ddram_addr, mode_4bit, proto_err);
        @(posedge clk); #1;
        m_valid = 0;
    endtask

    task automatic send_byte(input bit rs, input logic [7:0] b);
        strobe(rs, 0, b[7:4]);
        strobe(rs, 0, b[3:0]);
    endtask

    task automatic init_seq();
        strobe(0, 0, 4'h3);
        strobe(0, 0, 4'h3);
        strobe(0, 0, 4'h3);
        strobe(0, 0, 4'h2);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1; lcde = 0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        $display("reset pulse");
    endtask

    task automatic read_ram(input logic [6:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        rd_addr = a;
        @(posedge clk); #1;
        d = rd_data;
        $display("read addr=%0h data=%0h", a, d);
    endtask

    task automatic reset_literals(input string tag);
        chk({tag, "_valid"}, byte_valid, 1'b0);
        chk({tag, "_rs"}, byte_rs, 1'b0);
        chk({tag, "_data"}, byte_data, 8'h00);
        chk({tag, "_addr"}, ddram_addr, 7'h00);
        chk({tag, "_mode"}, mode_4bit, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err"}, proto_err, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        model_reset();
        for (int i = 0; i < 128; i++) ram_known[i] = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        reset_literals("rst");

        // Init handshake
        strobe(0, 0, 4'h3);
        strobe(0, 0, 4'h3);
        strobe(0, 0, 4'h3);
        chk("init_mode_pre", mode_4bit, 1'b0);
        strobe(0, 0, 4'h2);
        chk("init_mode", mode_4bit, 1'b1);
        chk("init_err", proto_err, 1'b0);

        // Set address then write
        send_byte(0, 8'hC5);
        chk("set_addr", ddram_addr, 7'h45);
        send_byte(1, 8'h41);
        chk("wr_addr", ddram_addr, 7'h46);
        read_ram(7'h45, d);
        chk("rd_45", d, 8'h41);

        // Address wrap
        send_byte(0, 8'hFF);
        send_byte(1, 8'h5A);
        send_byte(1, 8'h5B);
        chk("wrap_addr", ddram_addr, 7'h01);
        read_ram(7'h7F, d);
        chk("rd_7f", d, 8'h5A);
        read_ram(7'h00, d);
        chk("rd_00", d, 8'h5B);

        // Function set: reported only
        send_byte(0, 8'h28);
        chk("fset_addr", ddram_addr, 7'h01);

`ifdef LCD_RESP_CLEAR_EN
        send_byte(1, 8'h77);
        @(posedge clk); #1 busy_cycles = 0;
        send_byte(0, 8'h01);
        chk("clr_busy", busy, 1'b1);
        chk("clr_addr", ddram_addr, 7'h00);
        chk("clr_err_pre", proto_err, 1'b0);
        strobe(1, 0, 4'h9);
        chk("clr_err_busy", proto_err, 1'b1);
        repeat (CLR + 4) @(posedge clk);
        #1;
        chk("clr_busy_done", busy, 1'b0);
        chk("clr_busy_len", busy_cycles, CLR);
        for (int i = 0; i < 128; i++) begin
            read_ram(7'(i), d);
            chk("clr_fill", d, 8'h20);
        end
`else
        send_byte(0, 8'h01);
        chk("clr_off_busy", busy, 1'b0);
        chk("clr_off_addr", ddram_addr, 7'h01);
`endif

        // Read strobe is ignored and flagged
        do_reset();
        init_seq();
        strobe(0, 1, 4'hA);
        chk("rw_err", proto_err, 1'b1);
        send_byte(0, 8'h90);
        chk("rw_ignored", ddram_addr, 7'h10);

        // Bad first init nibble keeps INIT0
        do_reset();
        strobe(0, 0, 4'h5);
        chk("init_bad_err", proto_err, 1'b1);
        strobe(0, 0, 4'h3);
        strobe(0, 0, 4'h3);
        strobe(0, 0, 4'h2);
        chk("init_bad_mode", mode_4bit, 1'b0);

        // Reset in the middle of a byte
        do_reset();
        init_seq();
        strobe(0, 0, 4'h8);
        do_reset();
        reset_literals("mid");
        init_seq();
        send_byte(0, 8'h93);
        chk("mid_addr", ddram_addr, 7'h13);
        send_byte(1, 8'h37);
        read_ram(7'h13, d);
        chk("mid_rd", d, 8'h37);

        // Every RAM location the model knows about
        for (int i = 0; i < 128; i++) begin
            if (ram_known[i]) begin
                read_ram(7'(i), d);
                chk("ram_model", d, ram_m[i]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
